// File: rtl/EE_pkg.sv
// -----------------------------------------------------------------------------
// EE_pkg
// Shared definitions for the CDR loop blocks that meet on the loop-filter node.
//   EEnet      : Thevenin source description of a node driver. V is the source
//                voltage, R the source resistance, C a spare capacitance term.
//                Each field holds an IEEE-754 double bit pattern, so the value
//                crosses ports as plain bits ($realtobits / $bitstoreal).
//   EE_HIZ     : an undriven node (0 V behind 1 TOhm).
//   pd_state_t : pulse FSM state of dms_bbpd_cp, exported so benches can use it.
// -----------------------------------------------------------------------------
package EE_pkg;

   typedef struct packed {
      logic [63:0] V;
      logic [63:0] R;
      logic [63:0] C;
   } EEnet;

   localparam EEnet EE_HIZ = '{
      V: $realtobits(0.0),
      R: $realtobits(1e12),
      C: $realtobits(0.0)
   };

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE_UP = 2'd1,
      PULSE_DN = 2'd2
   } pd_state_t;

endpackage

// File: rtl/dms_cp_drv.sv
// -----------------------------------------------------------------------------
// dms_cp_drv
// Charge-pump output stage: turns the pulse FSM state into the Thevenin source
// seen by the loop-filter node.
//   state : pulse FSM state (IDLE / PULSE_UP / PULSE_DN)
//   P     : EEnet drive onto the loop-filter node
// -----------------------------------------------------------------------------
module dms_cp_drv
   import EE_pkg::*;
#(
   parameter real V_CP = 1.2,
   parameter real R_CP = 10e3
) (
   input  pd_state_t state,
   output EEnet      P
);

   localparam EEnet EE_UP = '{V: $realtobits(V_CP), R: $realtobits(R_CP), C: $realtobits(0.0)};
   localparam EEnet EE_DN = '{V: $realtobits(0.0),  R: $realtobits(R_CP), C: $realtobits(0.0)};

   always_comb begin
      // NOTE: default assigned first so every path drives P and no latch is inferred.
      P = EE_HIZ;
      case (state)
         PULSE_UP: P = EE_UP;
         PULSE_DN: P = EE_DN;
         default:  P = EE_HIZ;
      endcase
   end

endmodule

// File: rtl/dms_bbpd_cp.sv
// -----------------------------------------------------------------------------
// dms_bbpd_cp
// Alexander bang-bang phase detector with windowed decision accumulation and a
// fixed-width charge-pump pulse generator feeding the loop-filter node.
//   clk    : recovered clock; data sampled on posedge, edge sample on negedge
//   rst_n  : asynchronous active-low reset
//   din    : serial data
//   en     : loop enable; low clears accumulation, lock and any active pulse
//   P      : Thevenin drive onto the loop-filter node (shared with dms_lpf)
//   up/dn  : charge-pump pulse active (never both)
//   locked : LOCK_WIN consecutive pulse-free windows seen
//   acc    : accumulator value (debug); shows the final window sum for the
//            cycle right after a window closes
// -----------------------------------------------------------------------------
module dms_bbpd_cp
   import EE_pkg::*;
#(
   parameter int  WIN      = 16,
   parameter int  THRESH   = 4,
   parameter int  PW       = 4,
   parameter int  LOCK_WIN = 8,
   parameter real V_CP     = 1.2,
   parameter real R_CP     = 10e3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          din,
   input  logic                          en,
   output EEnet                          P,
   output logic                          up,
   output logic                          dn,
   output logic                          locked,
   output logic signed [$clog2(WIN)+1:0] acc
);

   localparam int ACC_W = $clog2(WIN) + 2;
   localparam int WC_W  = $clog2(WIN);
   localparam int LC_W  = $clog2(LOCK_WIN + 1);
   localparam int PC_W  = $clog2(PW + 1);

   localparam logic signed [ACC_W-1:0] ZERO    = '0;
   localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);
   localparam logic signed [ACC_W-1:0] M_ONE   = -ONE;
   localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
   localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;

   if (WIN < 2) begin : g_bad_win
      $fatal(1, "dms_bbpd_cp: WIN must be at least 2");
   end
   if (PW < 1 || PW >= WIN) begin : g_bad_pw
      $fatal(1, "dms_bbpd_cp: PW must satisfy 1 <= PW < WIN");
   end

   // ---------------- samplers (run regardless of en) ----------------
   logic d_q;        // d[n-1] while din presents d[n] at the posedge
   logic e_q;        // edge sample taken on the negedge between d[n-1] and d[n]
   logic have_prev;  // a previous data sample is held

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement or process order.
      if (!rst_n) begin
         d_q       <= 1'b0;
         have_prev <= 1'b0;
      end else begin
         d_q       <= din;
         have_prev <= 1'b1;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) e_q <= 1'b0;
      else        e_q <= din;
   end

   // Decision: edge sample matching the new bit means the clock is late (+1),
   // matching the old bit means early (-1).
   logic signed [ACC_W-1:0] dec;
   always_comb begin
      dec = ZERO;
      if (have_prev && (din != d_q)) dec = (e_q == din) ? ONE : M_ONE;
   end

   // ---------------- window accumulation ----------------
   logic signed [ACC_W-1:0] acc_q, base, sum;
   logic                    restart_q;  // previous cycle closed a window
   logic [WC_W-1:0]         win_cnt;
   logic [LC_W-1:0]         lock_cnt;
   logic                    wrap, fire_up, fire_dn;

   // acc_q keeps the closed window's sum for one cycle; the next window
   // starts from zero instead of building on it.
   assign base    = restart_q ? ZERO : acc_q;
   assign sum     = base + dec;
   assign wrap    = en && (win_cnt == WC_W'(WIN - 1));
   assign fire_up = wrap && (sum >= THR_POS);
   assign fire_dn = wrap && (sum <= THR_NEG);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= ZERO;
         restart_q <= 1'b0;
         win_cnt   <= '0;
         lock_cnt  <= '0;
      end else if (!en) begin
         acc_q     <= ZERO;
         restart_q <= 1'b0;
         win_cnt   <= '0;
         lock_cnt  <= '0;
      end else begin
         acc_q     <= sum;
         restart_q <= wrap;
         if (wrap) begin
            win_cnt <= '0;
            if (fire_up || fire_dn)                  lock_cnt <= '0;
            else if (lock_cnt != LC_W'(LOCK_WIN))    lock_cnt <= lock_cnt + 1'b1;
         end else begin
            win_cnt <= win_cnt + 1'b1;
         end
      end
   end

   // ---------------- pulse FSM ----------------
   pd_state_t       state_q, state_d;
   logic [PC_W-1:0] pw_cnt;
   logic            pw_done;

   assign pw_done = (pw_cnt == PC_W'(PW - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (fire_up)      state_d = PULSE_UP;
            else if (fire_dn) state_d = PULSE_DN;
         end
         PULSE_UP, PULSE_DN: if (pw_done) state_d = IDLE;
         default:            state_d = IDLE;
      endcase
      if (!en) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pw_cnt  <= '0;
      end else begin
         state_q <= state_d;
         // Count only while staying in the same pulse state; entry restarts at 0.
         if (state_q != IDLE && state_d == state_q) pw_cnt <= pw_cnt + 1'b1;
         else                                       pw_cnt <= '0;
      end
   end

   assign up     = (state_q == PULSE_UP);
   assign dn     = (state_q == PULSE_DN);
   assign locked = (lock_cnt == LC_W'(LOCK_WIN));
   assign acc    = acc_q;

   dms_cp_drv #(
      .V_CP (V_CP),
      .R_CP (R_CP)
   ) u_drv (
      .state (state_q),
      .P     (P)
   );

endmodule

// File: tb/tb_dms_bbpd_cp.sv
// -----------------------------------------------------------------------------
// tb_dms_bbpd_cp
// Directed bench for dms_bbpd_cp with default parameters (WIN=16, THRESH=4,
// PW=4, LOCK_WIN=8, V_CP=1.2, R_CP=10e3). Each bit period drives din to an
// edge value before the negedge and to the data value before the posedge, so
// late/early/no-transition decisions are chosen per cycle. Outputs are read
// 1 time unit after the posedge.
// -----------------------------------------------------------------------------
module tb_dms_bbpd_cp;
   import EE_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              din;
   logic              en;
   EEnet              P;
   logic              up;
   logic              dn;
   logic              locked;
   logic signed [5:0] acc;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic cur   = 1'b0;   // last data bit driven
   real  v_r;
   real  r_r;

   dms_bbpd_cp dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din),
      .en     (en),
      .P      (P),
      .up     (up),
      .dn     (dn),
      .locked (locked),
      .acc    (acc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One bit period: edge value at the negedge, data value at the posedge.
   task automatic cycle(input logic e_bit, input logic d_bit);
      din = e_bit;
      @(negedge clk);
      #1 din = d_bit;
      @(posedge clk);
      #1;
   endtask

   task automatic late();  cycle(~cur, ~cur); cur = ~cur; endtask
   task automatic early(); cycle(cur, ~cur);  cur = ~cur; endtask
   task automatic quiet(); cycle(cur, cur);               endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; din = 1'b0; cur = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (up !== 1'b0)     begin n_bad++; $display("FAIL reset_up: got %b want 0", up); end
      n_cmp++; if (dn !== 1'b0)     begin n_bad++; $display("FAIL reset_dn: got %b want 0", dn); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
      n_cmp++; if (acc !== 6'sd0)   begin n_bad++; $display("FAIL reset_acc: got %0d want 0", acc); end
      n_cmp++; if (P !== EE_HIZ)    begin n_bad++; $display("FAIL reset_P: got %h want %h", P, EE_HIZ); end
      rst_n = 1'b1;
      repeat (2) quiet();
   endtask

   task automatic test_late();
      en = 1'b1;
      repeat (15) late();
      n_cmp++; if (acc !== 6'sd15) begin n_bad++; $display("FAIL late_acc15: got %0d want 15", acc); end
      n_cmp++; if (up !== 1'b0)    begin n_bad++; $display("FAIL late_early_up: got %b want 0", up); end
      late();
      v_r = $bitstoreal(P.V); r_r = $bitstoreal(P.R);
      n_cmp++; if (up !== 1'b1)    begin n_bad++; $display("FAIL late_up: got %b want 1", up); end
      n_cmp++; if (dn !== 1'b0)    begin n_bad++; $display("FAIL late_dn: got %b want 0", dn); end
      n_cmp++; if (acc !== 6'sd16) begin n_bad++; $display("FAIL late_acc16: got %0d want 16", acc); end
      n_cmp++; if (v_r != 1.2)     begin n_bad++; $display("FAIL late_PV: got %f want 1.2", v_r); end
      n_cmp++; if (r_r != 10e3)    begin n_bad++; $display("FAIL late_PR: got %f want 10000", r_r); end
      for (int i = 0; i < 3; i++) begin
         quiet();
         n_cmp++; if (up !== 1'b1) begin n_bad++; $display("FAIL late_hold%0d: up=%b want 1", i, up); end
         if (i == 0) begin
            n_cmp++; if (acc !== 6'sd0) begin n_bad++; $display("FAIL late_restart: acc=%0d want 0", acc); end
         end
      end
      quiet();
      n_cmp++; if (up !== 1'b0)  begin n_bad++; $display("FAIL late_end: up=%b want 0", up); end
      n_cmp++; if (P !== EE_HIZ) begin n_bad++; $display("FAIL late_end_P: got %h want %h", P, EE_HIZ); end
      en = 1'b0; quiet();
   endtask

   task automatic test_early();
      en = 1'b1;
      repeat (16) early();
      v_r = $bitstoreal(P.V); r_r = $bitstoreal(P.R);
      n_cmp++; if (dn !== 1'b1)     begin n_bad++; $display("FAIL early_dn: got %b want 1", dn); end
      n_cmp++; if (up !== 1'b0)     begin n_bad++; $display("FAIL early_up: got %b want 0", up); end
      n_cmp++; if (acc !== -6'sd16) begin n_bad++; $display("FAIL early_acc: got %0d want -16", acc); end
      n_cmp++; if (v_r != 0.0)      begin n_bad++; $display("FAIL early_PV: got %f want 0.0", v_r); end
      n_cmp++; if (r_r != 10e3)     begin n_bad++; $display("FAIL early_PR: got %f want 10000", r_r); end
      for (int i = 0; i < 3; i++) begin
         quiet();
         n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL early_hold%0d: dn=%b want 1", i, dn); end
      end
      quiet();
      n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL early_end: dn=%b want 0", dn); end
      en = 1'b0; quiet();
   endtask

   task automatic test_threshold();
      en = 1'b1;
      repeat (3) late();
      repeat (13) quiet();
      n_cmp++; if (acc !== 6'sd3)         begin n_bad++; $display("FAIL thr3_acc: got %0d want 3", acc); end
      n_cmp++; if ({up, dn} !== 2'b00)    begin n_bad++; $display("FAIL thr3_pulse: up/dn=%b want 00", {up, dn}); end
      repeat (4) late();
      repeat (12) quiet();
      n_cmp++; if (acc !== 6'sd4)         begin n_bad++; $display("FAIL thr4_acc: got %0d want 4", acc); end
      n_cmp++; if ({up, dn} !== 2'b10)    begin n_bad++; $display("FAIL thr4_pulse: up/dn=%b want 10", {up, dn}); end
      repeat (4) quiet();
      en = 1'b0; quiet();
   endtask

   task automatic test_lock();
      en = 1'b1;
      repeat (7 * 16) quiet();
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_7: got %b want 0", locked); end
      repeat (16) quiet();
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_8: got %b want 1", locked); end
      repeat (16) quiet();
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_9: got %b want 1", locked); end
      repeat (16) late();
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_fire: got %b want 0", locked); end
      n_cmp++; if (up !== 1'b1)     begin n_bad++; $display("FAIL lock_fire_up: got %b want 1", up); end
      repeat (4) quiet();
      en = 1'b0; quiet();
   endtask

   task automatic test_enable();
      en = 1'b1;
      repeat (16) late();
      quiet();
      n_cmp++; if (up !== 1'b1)     begin n_bad++; $display("FAIL en_pulse2: up=%b want 1", up); end
      en = 1'b0;
      quiet();
      n_cmp++; if (up !== 1'b0)     begin n_bad++; $display("FAIL en_drop_up: got %b want 0", up); end
      n_cmp++; if (acc !== 6'sd0)   begin n_bad++; $display("FAIL en_drop_acc: got %0d want 0", acc); end
      n_cmp++; if (P !== EE_HIZ)    begin n_bad++; $display("FAIL en_drop_P: got %h want %h", P, EE_HIZ); end
      en = 1'b1;
      repeat (8 * 16) quiet();
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL en_relock: got %b want 1", locked); end
      en = 1'b0;
      quiet();
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL en_drop_locked: got %b want 0", locked); end
   endtask

   task automatic test_reset_mid_pulse();
      en = 1'b1;
      repeat (16) late();
      quiet();
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({up, dn} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_updn: got %b want 00", {up, dn}); end
      n_cmp++; if (acc !== 6'sd0)      begin n_bad++; $display("FAIL rst_mid_acc: got %0d want 0", acc); end
      n_cmp++; if (P !== EE_HIZ)       begin n_bad++; $display("FAIL rst_mid_P: got %h want %h", P, EE_HIZ); end
      #2 rst_n = 1'b1;
      // First posedge after reset holds only one data sample: no decision.
      for (int i = 0; i < 15; i++) begin
         late();
         n_cmp++; if (up !== 1'b0) begin n_bad++; $display("FAIL rst_nopulse%0d: up=%b want 0", i, up); end
      end
      late();
      n_cmp++; if (up !== 1'b1)     begin n_bad++; $display("FAIL rst_after_up: got %b want 1", up); end
      n_cmp++; if (acc !== 6'sd15)  begin n_bad++; $display("FAIL rst_after_acc: got %0d want 15", acc); end
      repeat (4) quiet();
      en = 1'b0; quiet();
   endtask

   initial begin
      test_reset();
      test_late();
      test_early();
      test_threshold();
      test_lock();
      test_enable();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
